alu_controller: RTL and testbench
=================================

ALU_CONTROLLER -- requirements
Module: alu_controller

Interface
REQ-001 Parameter: N, 4, operand/result width; it SHALL match the width of the ALU instance it drives.
REQ-002 Ports (name, direction, width, meaning):
- clk_i, in, 1, single clock.
- rst_i, in, 1, reset; asynchronous, active-high.
- instr_valid_i, in, 1, instruction offered.
- instr_ready_o, out, 1, controller can accept an instruction.
- instr_op_i, in, 3, operation: 000 SUM, 001 RES, 010 MUL, 011 CMP, 100 MOV; other codes are illegal.
- instr_cond_i, in, 2, condition: 00 AL, 01 EQ (Z=1), 10 NE (Z=0), 11 MI (Nf=1).
- instr_s_i, in, 1, update the flag register.
- instr_a_i, in, N, operand A.
- instr_b_i, in, N, operand B.
- alu_a_o, out, N, ALU operand A.
- alu_b_o, out, N, ALU operand B.
- alu_opcode_o, out, 3, ALU opcode.
- alu_result_i, in, N, ALU result.
- alu_flags_i, in, 2, ALU flags: [0]=Z, [1]=Nf.
- result_valid_o, out, 1, response available.
- result_ready_i, in, 1, consumer accepts the response.
- result_o, out, N, response data.
- result_wr_o, out, 1, destination write required.
- result_exec_o, out, 1, condition passed and op executed.
- result_err_o, out, 1, illegal op.
- flags_o, out, 2, flag register: [0]=Z, [1]=Nf.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-004 IDLE: instr_ready_o SHALL be 1; on instr_valid_i=1, it SHALL latch op, cond, s, a and b, then go to EXEC; otherwise it SHALL stay in IDLE.
REQ-005 In EXEC and RESP, instr_ready_o SHALL be 0 and instr_valid_i SHALL be ignored.
REQ-006 Condition evaluation SHALL use flags_o as held at acceptance, i.e. before this instruction.
REQ-007 Op-to-ALU opcode mapping (alu_defs constants): SUM->ARITH_SUM, RES->ARITH_RES, MUL->ARITH_MUL, CMP->ARITH_RES, MOV->CR_.
REQ-008 alu_a_o, alu_b_o and alu_opcode_o SHALL be registered and updated on the IDLE->EXEC transition, for legal ops only; they SHALL hold their value in all other states.
REQ-009 EXEC lasts one cycle. At the end of EXEC the controller SHALL capture alu_result_i and alu_flags_i, then go to RESP.
REQ-010 Legal op, condition passed:
- result_o = captured result.
- result_exec_o = 1.
- result_wr_o = 1, except CMP, which SHALL give result_wr_o = 0.
- flags_o = captured alu_flags_i if instr_s_i=1; CMP SHALL update flags regardless of instr_s_i.
REQ-011 Legal op, condition failed: result_o = 0, result_exec_o = 0, result_wr_o = 0, flags_o unchanged.
REQ-012 Illegal op:
- result_err_o = 1; result_o, exec and wr = 0; flags_o unchanged.
- The ALU outputs SHALL not be updated.
- The EXEC cycle SHALL still occur, so latency is identical.
REQ-013 RESP: result_valid_o SHALL be 1, and all result_* outputs SHALL be stable until result_ready_i=1; on that cycle the FSM SHALL return to IDLE.
REQ-014 Latency: result_valid_o SHALL rise exactly 2 cycles after the accept edge; throughput is at most one instruction per 3 cycles.
REQ-015 Flags SHALL be taken from the ALU unmodified, with no recomputation.
- Example, MUL wrap with N=4: 4*4 gives result_o=0 and Z=0 (Z comes from the ALU's N+1-bit result).
REQ-016 Outside RESP, result_valid_o SHALL be 0, while the result_* data outputs hold their last values.

Reset
REQ-017 rst_i=1 SHALL immediately force state=IDLE and all outputs as follows:
- flags_o=00; result_valid_o=0; result_o=0; result_wr_o=0; result_exec_o=0; result_err_o=0.
- alu_a_o=0; alu_b_o=0; alu_opcode_o=ARITH_SUM.
- instr_ready_o=0 while rst_i is high, and 1 in the first cycle after release.
REQ-018 Reset asserted in EXEC or RESP SHALL discard the in-flight instruction; no response SHALL be produced after release.

Verification
REQ-019 AL SUM a=3 b=4 s=1 -> result_valid_o high 2 cycles after accept; result_o=7, wr=1, exec=1, flags_o=00.
REQ-020 AL CMP a=5 b=5 s=0, then EQ MOV b=9 -> first response: wr=0, exec=1, flags_o=01; second response: result_o=9, wr=1, exec=1.
REQ-021 With flags_o=01: NE SUM a=1 b=1 -> result_o=0, exec=0, wr=0, flags_o stays 01, alu_* outputs show SUM 1,1.
REQ-022 result_ready_i held 0 for 3 cycles during RESP -> result_valid_o and data stable, instr_ready_o=0; handshake on the 4th cycle -> IDLE, instr_ready_o=1 on the next cycle.
REQ-023 op=101 -> result_err_o=1, result_o=0, flags_o and alu_opcode_o unchanged, same 2-cycle latency.
REQ-024 rst_i pulsed asynchronously mid-EXEC -> all outputs at reset values before the next clock edge, no result_valid_o afterwards, next instruction accepted normally.

Source files
------------

// File: rtl/alu_controller.sv
// alu_controller: sequences one instruction at a time through an external
// combinational ALU. An instruction is accepted in IDLE. It drives the ALU
// during EXEC and captures the ALU result and flags at the end of EXEC. The
// response is then held in RESP until the consumer accepts it.
//
// Ports:
//   clk_i, rst_i (async, active-high)
//   instr_*  : instruction handshake (valid/ready), op, cond, s, operands a/b
//   alu_*_o  : registered operands and opcode to the ALU
//   alu_*_i  : ALU result and flags ([0]=Z, [1]=Nf)
//   result_* : response handshake (valid/ready), data, wr/exec/err qualifiers
//   flags_o  : architectural flag register ([0]=Z, [1]=Nf)
module alu_controller #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         instr_valid_i,
  output logic         instr_ready_o,
  input  logic [2:0]   instr_op_i,
  input  logic [1:0]   instr_cond_i,
  input  logic         instr_s_i,
  input  logic [N-1:0] instr_a_i,
  input  logic [N-1:0] instr_b_i,
  output logic [N-1:0] alu_a_o,
  output logic [N-1:0] alu_b_o,
  output logic [2:0]   alu_opcode_o,
  input  logic [N-1:0] alu_result_i,
  input  logic [1:0]   alu_flags_i,
  output logic         result_valid_o,
  input  logic         result_ready_i,
  output logic [N-1:0] result_o,
  output logic         result_wr_o,
  output logic         result_exec_o,
  output logic         result_err_o,
  output logic [1:0]   flags_o
);

  // ALU opcodes (must match the ALU's definitions)
  localparam logic [2:0] ARITH_SUM = 3'b000;
  localparam logic [2:0] ARITH_RES = 3'b001;
  localparam logic [2:0] ARITH_MUL = 3'b010;
  localparam logic [2:0] CR_       = 3'b011;

  // Instruction op codes
  localparam logic [2:0] OP_SUM = 3'b000;
  localparam logic [2:0] OP_RES = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_CMP = 3'b011;
  localparam logic [2:0] OP_MOV = 3'b100;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t       state_q;
  logic         cmp_q, s_q, pass_q, legal_q;
  logic [N-1:0] alu_a_q, alu_b_q, result_q;
  logic [2:0]   alu_opcode_q;
  logic         valid_q, wr_q, exec_q, err_q;
  logic [1:0]   flags_q;

  // Decode of the offered instruction, used only on the accept cycle
  logic         legal_d, pass_d;
  logic [2:0]   opcode_d;

  always_comb begin
    legal_d  = 1'b1;
    opcode_d = ARITH_SUM;
    case (instr_op_i)
      OP_SUM:         opcode_d = ARITH_SUM;
      OP_RES, OP_CMP: opcode_d = ARITH_RES;
      OP_MUL:         opcode_d = ARITH_MUL;
      OP_MOV:         opcode_d = CR_;
      default:        legal_d  = 1'b0;
    endcase
    // The condition is resolved against the flags as they stand at
    // acceptance, so this instruction can never observe its own update.
    pass_d = 1'b1;
    case (instr_cond_i)
      2'b00:   pass_d = 1'b1;
      2'b01:   pass_d = flags_q[0];
      2'b10:   pass_d = ~flags_q[0];
      default: pass_d = flags_q[1];
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cmp_q        <= 1'b0;
      s_q          <= 1'b0;
      pass_q       <= 1'b0;
      legal_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= ARITH_SUM;
      result_q     <= '0;
      valid_q      <= 1'b0;
      wr_q         <= 1'b0;
      exec_q       <= 1'b0;
      err_q        <= 1'b0;
      flags_q      <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (instr_valid_i) begin
            cmp_q   <= (instr_op_i == OP_CMP);
            s_q     <= instr_s_i;
            pass_q  <= pass_d;
            legal_q <= legal_d;
            // Illegal ops leave the ALU inputs untouched
            if (legal_d) begin
              alu_a_q      <= instr_a_i;
              alu_b_q      <= instr_b_i;
              alu_opcode_q <= opcode_d;
            end
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (!legal_q) begin
            result_q <= '0;
            wr_q     <= 1'b0;
            exec_q   <= 1'b0;
            err_q    <= 1'b1;
          end else if (pass_q) begin
            result_q <= alu_result_i;
            wr_q     <= ~cmp_q;
            exec_q   <= 1'b1;
            err_q    <= 1'b0;
            // CMP exists only to set flags, so it ignores the s bit
            if (s_q || cmp_q) flags_q <= alu_flags_i;
          end else begin
            result_q <= '0;
            wr_q     <= 1'b0;
            exec_q   <= 1'b0;
            err_q    <= 1'b0;
          end
          valid_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          if (result_ready_i) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Ready is decoded from the state rather than registered. This way it is
  // low throughout reset and already high in the first cycle after release.
  assign instr_ready_o  = (state_q == IDLE) & ~rst_i;
  assign result_valid_o = valid_q;
  assign result_o       = result_q;
  assign result_wr_o    = wr_q;
  assign result_exec_o  = exec_q;
  assign result_err_o   = err_q;
  assign flags_o        = flags_q;
  assign alu_a_o        = alu_a_q;
  assign alu_b_o        = alu_b_q;
  assign alu_opcode_o   = alu_opcode_q;

endmodule

// File: tb/tb_alu_controller.sv
// Testbench for alu_controller: directed scenarios plus a randomized run
// against an instruction-level reference model. A small combinational ALU
// model stands in for the ALU the controller drives.
module tb_alu_controller;
  localparam int N = 4;
  localparam logic [2:0] ARITH_SUM = 3'b000;
  localparam logic [2:0] ARITH_RES = 3'b001;
  localparam logic [2:0] ARITH_MUL = 3'b010;
  localparam logic [2:0] CR_       = 3'b011;

  logic         clk = 1'b0, rst = 1'b0;
  logic         instr_valid = 1'b0, result_ready = 1'b0, instr_s = 1'b0;
  logic [2:0]   instr_op = '0;
  logic [1:0]   instr_cond = '0;
  logic [N-1:0] instr_a = '0, instr_b = '0;
  logic         instr_ready_o, result_valid_o, result_wr_o, result_exec_o, result_err_o;
  logic [N-1:0] alu_a_o, alu_b_o, alu_result, result_o;
  logic [2:0]   alu_opcode_o;
  logic [1:0]   alu_flags, flags_o;

  int checks = 0, fails = 0;

  alu_controller #(.N(N)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_valid_i(instr_valid), .instr_ready_o(instr_ready_o),
    .instr_op_i(instr_op), .instr_cond_i(instr_cond), .instr_s_i(instr_s),
    .instr_a_i(instr_a), .instr_b_i(instr_b),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_opcode_o(alu_opcode_o),
    .alu_result_i(alu_result), .alu_flags_i(alu_flags),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready),
    .result_o(result_o), .result_wr_o(result_wr_o), .result_exec_o(result_exec_o),
    .result_err_o(result_err_o), .flags_o(flags_o)
  );

  always #5 clk = ~clk;

  // ALU environment: N+1-bit result; Z is taken from all N+1 bits, Nf from bit N
  logic [N:0] alu_full;
  always_comb begin
    alu_full = '0;
    case (alu_opcode_o)
      ARITH_SUM: alu_full = {1'b0, alu_a_o} + {1'b0, alu_b_o};
      ARITH_RES: alu_full = {1'b0, alu_a_o} - {1'b0, alu_b_o};
      ARITH_MUL: alu_full = {1'b0, alu_a_o} * {1'b0, alu_b_o};
      CR_:       alu_full = {1'b0, alu_b_o};
      default:   alu_full = '0;
    endcase
    alu_result = alu_full[N-1:0];
    alu_flags  = {alu_full[N], (alu_full == '0)};
  end

  // Instruction-level reference model state
  logic [1:0]   m_flags;
  logic [N-1:0] m_a, m_b;
  logic [2:0]   m_opc;

  // Expected response {result, wr, exec, err}; updates model flags/ALU inputs
  task automatic model(input logic [2:0] op, input logic [1:0] cond, input logic s,
                       input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic [N+2:0] exp);
    logic pass;
    logic [N:0] full;
    pass = (cond == 2'd0) ? 1'b1 : (cond == 2'd1) ? m_flags[0] :
           (cond == 2'd2) ? ~m_flags[0] : m_flags[1];
    full = '0;
    case (op)
      3'd0:       full = {1'b0, a} + {1'b0, b};
      3'd1, 3'd3: full = {1'b0, a} - {1'b0, b};
      3'd2:       full = {1'b0, a} * {1'b0, b};
      3'd4:       full = {1'b0, b};
      default:    full = '0;
    endcase
    if (op > 3'd4) begin
      exp = {{N{1'b0}}, 3'b001};
    end else begin
      m_a = a;
      m_b = b;
      m_opc = (op == 3'd0) ? ARITH_SUM : (op == 3'd2) ? ARITH_MUL :
              (op == 3'd4) ? CR_ : ARITH_RES;
      if (pass) begin
        exp = {full[N-1:0], (op != 3'd3), 1'b1, 1'b0};
        if (s || op == 3'd3) m_flags = {full[N], (full == '0)};
      end else begin
        exp = '0;
      end
    end
  endtask

  // Offer one instruction in IDLE; returns 1 ns after the accept edge
  task automatic send(input logic [2:0] op, input logic [1:0] cond, input logic s,
                      input logic [N-1:0] a, input logic [N-1:0] b);
    instr_valid = 1'b1; instr_op = op; instr_cond = cond; instr_s = s;
    instr_a = a; instr_b = b;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr_op = 3'($urandom); instr_a = N'($urandom); instr_b = N'($urandom);
  endtask

  task automatic ack();
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; #2;
    checks++;
    if ({instr_ready_o, result_valid_o, result_o, result_wr_o, result_exec_o, result_err_o,
         flags_o, alu_a_o, alu_b_o, alu_opcode_o} !==
        {2'b00, {N{1'b0}}, 3'b000, 2'b00, {N{1'b0}}, {N{1'b0}}, ARITH_SUM}) begin
      fails++; $display("FAIL reset_outputs got ready=%b valid=%b res=%h flags=%b opc=%h", instr_ready_o,
                        result_valid_o, result_o, flags_o, alu_opcode_o);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; #1;
    checks++;
    if (instr_ready_o !== 1'b1) begin
      fails++; $display("FAIL reset_release_ready got %b want 1", instr_ready_o);
    end
  endtask

  task automatic test_sum();
    send(3'd0, 2'd0, 1'b1, 4'd3, 4'd4);
    checks++;
    if ({result_valid_o, alu_a_o, alu_b_o, alu_opcode_o} !== {1'b0, 4'd3, 4'd4, ARITH_SUM}) begin
      fails++; $display("FAIL sum_exec got v=%b a=%h b=%h opc=%h", result_valid_o, alu_a_o, alu_b_o, alu_opcode_o);
    end
    @(posedge clk); #1;
    checks++;
    if ({result_valid_o, result_o, result_wr_o, result_exec_o, result_err_o, flags_o} !==
        {1'b1, 4'd7, 3'b110, 2'b00}) begin
      fails++; $display("FAIL sum_resp got v=%b res=%h wr=%b ex=%b err=%b fl=%b want 1 7 1 1 0 00", result_valid_o,
                        result_o, result_wr_o, result_exec_o, result_err_o, flags_o);
    end
    ack();
    checks++;
    if ({result_valid_o, instr_ready_o} !== 2'b01) begin
      fails++; $display("FAIL sum_handshake got valid=%b ready=%b want 0 1", result_valid_o, instr_ready_o);
    end
    // 4*4 wraps to 0 while the ALU still reports Z=0 (Nf=1 from bit N)
    send(3'd2, 2'd0, 1'b1, 4'd4, 4'd4);
    @(posedge clk); #1;
    checks++;
    if ({result_valid_o, result_o, result_wr_o, result_exec_o, result_err_o, flags_o} !==
        {1'b1, 4'd0, 3'b110, 2'b10}) begin
      fails++; $display("FAIL mul_wrap got res=%h fl=%b want 0 10", result_o, flags_o);
    end
    ack();
  endtask

  task automatic test_cmp_mov();
    send(3'd3, 2'd0, 1'b0, 4'd5, 4'd5);
    @(posedge clk); #1;
    checks++;
    if ({result_valid_o, result_wr_o, result_exec_o, result_err_o, flags_o} !== {1'b1, 3'b010, 2'b01}) begin
      fails++; $display("FAIL cmp_resp got wr=%b ex=%b err=%b fl=%b want 0 1 0 01", result_wr_o, result_exec_o,
                        result_err_o, flags_o);
    end
    ack();
    send(3'd4, 2'd1, 1'b0, 4'd2, 4'd9);
    @(posedge clk); #1;
    checks++;
    if ({result_valid_o, result_o, result_wr_o, result_exec_o, result_err_o, flags_o} !==
        {1'b1, 4'd9, 3'b110, 2'b01}) begin
      fails++; $display("FAIL mov_eq got res=%h wr=%b ex=%b fl=%b want 9 1 1 01", result_o, result_wr_o,
                        result_exec_o, flags_o);
    end
    ack();
  endtask

  task automatic test_cond_fail();
    send(3'd0, 2'd2, 1'b1, 4'd1, 4'd1);
    checks++;
    if ({alu_a_o, alu_b_o, alu_opcode_o} !== {4'd1, 4'd1, ARITH_SUM}) begin
      fails++; $display("FAIL ne_alu got a=%h b=%h opc=%h want 1 1 %h", alu_a_o, alu_b_o, alu_opcode_o, ARITH_SUM);
    end
    @(posedge clk); #1;
    checks++;
    if ({result_valid_o, result_o, result_wr_o, result_exec_o, result_err_o, flags_o} !==
        {1'b1, 4'd0, 3'b000, 2'b01}) begin
      fails++; $display("FAIL ne_skip got res=%h wr=%b ex=%b fl=%b want 0 0 0 01", result_o, result_wr_o,
                        result_exec_o, flags_o);
    end
    ack();
  endtask

  task automatic test_backpressure();
    send(3'd1, 2'd0, 1'b0, 4'd9, 4'd3);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({result_valid_o, instr_ready_o, result_o, result_wr_o, result_exec_o, result_err_o, flags_o} !==
          {2'b10, 4'd6, 3'b110, 2'b01}) begin
        fails++; $display("FAIL stall_hold cycle %0d got v=%b rdy=%b res=%h fl=%b", i, result_valid_o,
                          instr_ready_o, result_o, flags_o);
      end
      @(posedge clk); #1;
    end
    ack();
    checks++;
    if ({result_valid_o, instr_ready_o} !== 2'b01) begin
      fails++; $display("FAIL stall_release got valid=%b ready=%b want 0 1", result_valid_o, instr_ready_o);
    end
  endtask

  task automatic test_illegal();
    send(3'd5, 2'd0, 1'b1, 4'd7, 4'd7);
    checks++;
    if (result_valid_o !== 1'b0) begin
      fails++; $display("FAIL illegal_latency early valid=%b", result_valid_o);
    end
    @(posedge clk); #1;
    checks++;
    if ({result_valid_o, result_o, result_wr_o, result_exec_o, result_err_o, flags_o,
         alu_a_o, alu_b_o, alu_opcode_o} !== {1'b1, 4'd0, 3'b001, 2'b01, 4'd9, 4'd3, ARITH_RES}) begin
      fails++; $display("FAIL illegal_resp got v=%b res=%h err=%b fl=%b a=%h b=%h opc=%h", result_valid_o,
                        result_o, result_err_o, flags_o, alu_a_o, alu_b_o, alu_opcode_o);
    end
    ack();
  endtask

  task automatic test_async_reset();
    send(3'd0, 2'd0, 1'b1, 4'd2, 4'd2);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({instr_ready_o, result_valid_o, result_o, result_wr_o, result_exec_o, result_err_o,
         flags_o, alu_a_o, alu_b_o, alu_opcode_o} !==
        {2'b00, {N{1'b0}}, 3'b000, 2'b00, {N{1'b0}}, {N{1'b0}}, ARITH_SUM}) begin
      fails++; $display("FAIL async_reset got v=%b res=%h fl=%b a=%h opc=%h", result_valid_o, result_o,
                        flags_o, alu_a_o, alu_opcode_o);
    end
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({result_valid_o, instr_ready_o} !== 2'b01) begin
        fails++; $display("FAIL async_discard cycle %0d got valid=%b ready=%b", i, result_valid_o, instr_ready_o);
      end
    end
    send(3'd0, 2'd0, 1'b1, 4'd1, 4'd2);
    @(posedge clk); #1;
    checks++;
    if ({result_valid_o, result_o, result_wr_o, result_exec_o, result_err_o, flags_o} !==
        {1'b1, 4'd3, 3'b110, 2'b00}) begin
      fails++; $display("FAIL async_next got v=%b res=%h fl=%b want 1 3 00", result_valid_o, result_o, flags_o);
    end
    ack();
  endtask

  task automatic test_random();
    logic [2:0] op; logic [1:0] cond; logic s; logic [N-1:0] a, b;
    logic [N+2:0] exp;
    int d;
    rst = 1'b1; #2 rst = 1'b0;
    m_flags = 2'b00; m_a = '0; m_b = '0; m_opc = ARITH_SUM;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7)); cond = 2'($urandom); s = 1'($urandom);
      a = N'($urandom); b = N'($urandom);
      model(op, cond, s, a, b, exp);
      send(op, cond, s, a, b);
      checks++;
      if ({result_valid_o, alu_a_o, alu_b_o, alu_opcode_o} !== {1'b0, m_a, m_b, m_opc}) begin
        fails++; $display("FAIL rand_alu #%0d got v=%b a=%h b=%h opc=%h want 0 %h %h %h", i, result_valid_o,
                          alu_a_o, alu_b_o, alu_opcode_o, m_a, m_b, m_opc);
      end
      @(posedge clk); #1;
      checks++;
      if ({result_valid_o, result_o, result_wr_o, result_exec_o, result_err_o, flags_o} !==
          {1'b1, exp, m_flags}) begin
        fails++; $display("FAIL rand_resp #%0d op=%0d cond=%0d got v=%b %h%b%b%b fl=%b want %h fl=%b", i, op,
                          cond, result_valid_o, result_o, result_wr_o, result_exec_o, result_err_o, flags_o,
                          exp, m_flags);
      end
      d = $urandom_range(0, 2);
      repeat (d) begin @(posedge clk); #1; end
      ack();
      checks++;
      if ({result_valid_o, instr_ready_o} !== 2'b01) begin
        fails++; $display("FAIL rand_idle #%0d got valid=%b ready=%b", i, result_valid_o, instr_ready_o);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sum();
    test_cmp_mov();
    test_cond_fail();
    test_backpressure();
    test_illegal();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
